// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner
//   Turns a stream of aligned fetch words into one 32-bit instruction per
//   valid/ready transfer. Fetch words are stored in a circular halfword
//   buffer. This lets a 32-bit instruction straddle a word boundary. RV32C
//   encodings are expanded through decomp_unit.
//
// Build option
//   RVC_ILLEGAL_CHK_EN : when defined, illegal 16-bit encodings raise
//                        inst_ill_o and force inst_o to zero. When it is not
//                        defined, inst_ill_o is tied to 0.
//
// Parameters
//   FETCH_W   fetch word width, 32 or 64
//   BUF_HW    halfword buffer depth, at least FETCH_W/16 + 1
//   RESET_PC  PC of the first instruction after reset
//
// Ports
//   clk_i, rst_n_i         clock and asynchronous active-low reset
//   flush_i, flush_pc_i    redirect: empty the buffer and restart at flush_pc_i
//   fetch_valid_i/ready_o  fetch word handshake; fetch_data_i holds the
//                          lowest address in bits [15:0]
//   inst_valid_o/ready_i   instruction handshake toward decode
//   inst_o, inst_pc_o      expanded instruction and the address of the
//                          original instruction
//   inst_is_c_o            the original instruction was 16-bit
//   inst_ill_o             illegal compressed encoding (build option only)

module decomp_unit (
  input  logic [15:0] inst_c,
  output logic [31:0] inst
);
  logic [4:0] rd;
  logic [4:0] rs2;
  logic [4:0] rd_p;
  logic [4:0] rs1_p;

  assign rd    = inst_c[11:7];
  assign rs2   = inst_c[6:2];
  assign rd_p  = {2'b01, inst_c[4:2]};
  assign rs1_p = {2'b01, inst_c[9:7]};

  always_comb begin
    inst = 32'h0;
    case ({inst_c[1:0], inst_c[15:13]})
      // quadrant 0
      5'b00_000: inst = {2'b00, inst_c[10:7], inst_c[12:11], inst_c[5], inst_c[6], 2'b00,
                         5'd2, 3'b000, rd_p, 7'b0010011};                     // c.addi4spn
      5'b00_010: inst = {5'b0, inst_c[5], inst_c[12:10], inst_c[6], 2'b00,
                         rs1_p, 3'b010, rd_p, 7'b0000011};                    // c.lw
      5'b00_110: inst = {5'b0, inst_c[5], inst_c[12], rd_p, rs1_p, 3'b010,
                         inst_c[11:10], inst_c[6], 2'b00, 7'b0100011};        // c.sw
      // quadrant 1
      5'b01_000: inst = {{6{inst_c[12]}}, inst_c[12], inst_c[6:2], rd, 3'b000,
                         rd, 7'b0010011};                                     // c.addi / c.nop
      5'b01_001: inst = {inst_c[12], inst_c[8], inst_c[10:9], inst_c[6], inst_c[7],
                         inst_c[2], inst_c[11], inst_c[5:3], inst_c[12],
                         {8{inst_c[12]}}, 5'd1, 7'b1101111};                  // c.jal
      5'b01_010: inst = {{6{inst_c[12]}}, inst_c[12], inst_c[6:2], 5'd0, 3'b000,
                         rd, 7'b0010011};                                     // c.li
      5'b01_011: begin
        if (rd == 5'd2)
          inst = {{3{inst_c[12]}}, inst_c[4:3], inst_c[5], inst_c[2], inst_c[6], 4'b0,
                  5'd2, 3'b000, 5'd2, 7'b0010011};                            // c.addi16sp
        else
          inst = {{15{inst_c[12]}}, inst_c[6:2], rd, 7'b0110111};             // c.lui
      end
      5'b01_100: begin
        case (inst_c[11:10])
          2'b00: inst = {7'b0000000, inst_c[6:2], rs1_p, 3'b101, rs1_p, 7'b0010011};
          2'b01: inst = {7'b0100000, inst_c[6:2], rs1_p, 3'b101, rs1_p, 7'b0010011};
          2'b10: inst = {{6{inst_c[12]}}, inst_c[12], inst_c[6:2], rs1_p, 3'b111,
                         rs1_p, 7'b0010011};
          default: begin
            if (!inst_c[12]) begin
              case (inst_c[6:5])
                2'b00:   inst = {7'b0100000, rd_p, rs1_p, 3'b000, rs1_p, 7'b0110011};
                2'b01:   inst = {7'b0000000, rd_p, rs1_p, 3'b100, rs1_p, 7'b0110011};
                2'b10:   inst = {7'b0000000, rd_p, rs1_p, 3'b110, rs1_p, 7'b0110011};
                default: inst = {7'b0000000, rd_p, rs1_p, 3'b111, rs1_p, 7'b0110011};
              endcase
            end
          end
        endcase
      end
      5'b01_101: inst = {inst_c[12], inst_c[8], inst_c[10:9], inst_c[6], inst_c[7],
                         inst_c[2], inst_c[11], inst_c[5:3], inst_c[12],
                         {8{inst_c[12]}}, 5'd0, 7'b1101111};                  // c.j
      5'b01_110: inst = {{4{inst_c[12]}}, inst_c[6:5], inst_c[2], 5'd0, rs1_p, 3'b000,
                         inst_c[11:10], inst_c[4:3], inst_c[12], 7'b1100011}; // c.beqz
      5'b01_111: inst = {{4{inst_c[12]}}, inst_c[6:5], inst_c[2], 5'd0, rs1_p, 3'b001,
                         inst_c[11:10], inst_c[4:3], inst_c[12], 7'b1100011}; // c.bnez
      // quadrant 2
      5'b10_000: inst = {7'b0, inst_c[6:2], rd, 3'b001, rd, 7'b0010011};      // c.slli
      5'b10_010: inst = {4'b0, inst_c[3:2], inst_c[12], inst_c[6:4], 2'b00,
                         5'd2, 3'b010, rd, 7'b0000011};                       // c.lwsp
      5'b10_100: begin
        if (!inst_c[12]) begin
          if (rs2 == 5'd0) inst = {12'b0, rd, 3'b000, 5'd0, 7'b1100111};      // c.jr
          else             inst = {7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};  // c.mv
        end else begin
          if (rs2 == 5'd0 && rd == 5'd0) inst = 32'h0010_0073;                // c.ebreak
          else if (rs2 == 5'd0) inst = {12'b0, rd, 3'b000, 5'd1, 7'b1100111}; // c.jalr
          else                  inst = {7'b0, rs2, rd, 3'b000, rd, 7'b0110011}; // c.add
        end
      end
      5'b10_110: inst = {4'b0, inst_c[8:7], inst_c[12], rs2, 5'd2, 3'b010,
                         inst_c[11:9], 2'b00, 7'b0100011};                    // c.swsp
      default:   inst = 32'h0;
    endcase
  end
endmodule

module rvc_fetch_aligner #(
  parameter int          FETCH_W  = 32,
  parameter int          BUF_HW   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic [31:0]        flush_pc_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [FETCH_W-1:0] fetch_data_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [31:0]        inst_o,
  output logic [31:0]        inst_pc_o,
  output logic               inst_is_c_o,
  output logic               inst_ill_o
);
  localparam int HW_PER_W = FETCH_W / 16;
  localparam int PTR_W    = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
  localparam int OCC_W    = $clog2(BUF_HW + 1);
  localparam int DROP_W   = $clog2(FETCH_W / 8) - 1;

  // Add n (always < BUF_HW) to a pointer, then wrap it modulo BUF_HW.
  // BUF_HW does not have to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= BUF_HW) s = s - BUF_HW;
    return s[PTR_W-1:0];
  endfunction

  logic [15:0]       buf_q [BUF_HW];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [OCC_W-1:0]  occ;
  logic [31:0]       pc_q;
  logic [DROP_W-1:0] drop_q;

  logic [15:0] h0;
  logic [15:0] h1;
  logic        is32;
  logic        enough;
  logic        pop;
  logic        accept;
  logic        ill;
  logic [31:0] exp_inst;
  int          n_wr;
  int          n_pop;

  assign h0     = buf_q[head];
  assign h1     = buf_q[ptr_add(head, 1)];
  assign is32   = (h0[1:0] == 2'b11);
  assign enough = is32 ? (occ >= OCC_W'(2)) : (occ != '0);

  assign inst_valid_o  = enough & ~flush_i;
  // The free space check uses the registered occupancy only. A pop in the
  // same cycle does not make room until the next cycle.
  assign fetch_ready_o = rst_n_i & ((BUF_HW - int'(occ)) >= HW_PER_W);

  assign pop    = inst_valid_o & inst_ready_i;
  assign accept = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign n_wr   = accept ? (HW_PER_W - int'(drop_q)) : 0;
  assign n_pop  = pop ? (is32 ? 2 : 1) : 0;

  decomp_unit u_decomp (
    .inst_c (h0),
    .inst   (exp_inst)
  );

`ifdef RVC_ILLEGAL_CHK_EN
  always_comb begin
    ill = 1'b0;
    if (!is32) begin
      if (h0 == 16'h0000) ill = 1'b1;
      if (h0[1:0] == 2'b00 && h0[15:13] == 3'b000 && h0[12:5] == 8'h00) ill = 1'b1;
      if (h0[1:0] == 2'b01 && h0[15:13] == 3'b011 && {h0[12], h0[6:2]} == 6'h00) ill = 1'b1;
      if (h0[1:0] == 2'b10 && h0[15:12] == 4'b1000 && h0[6:2] == 5'd0 && h0[11:7] == 5'd0)
        ill = 1'b1;
    end
  end
`else
  assign ill = 1'b0;
`endif

  // Outputs depend only on the buffer head and registered state. All outputs
  // read zero whenever no instruction is presented.
  always_comb begin
    inst_o      = 32'h0;
    inst_pc_o   = 32'h0;
    inst_is_c_o = 1'b0;
    inst_ill_o  = 1'b0;
    if (inst_valid_o) begin
      inst_pc_o   = pc_q;
      inst_is_c_o = ~is32;
      inst_ill_o  = ill;
      if (is32)      inst_o = {h1, h0};
      else if (!ill) inst_o = exp_inst;
    end
  end

  // The buffer storage has no reset. The occupancy counter alone decides
  // which entries are live.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < HW_PER_W; i++) begin
        if (i >= int'(drop_q))
          buf_q[ptr_add(tail, i - int'(drop_q))] <= fetch_data_i[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head   <= '0;
      tail   <= '0;
      occ    <= '0;
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else if (flush_i) begin
      head   <= '0;
      tail   <= '0;
      occ    <= '0;
      pc_q   <= flush_pc_i & 32'hFFFF_FFFE;
      // The redirect target may sit mid-word. Skip the halfwords below it in
      // the first word fetched after the flush.
      drop_q <= flush_pc_i[DROP_W:1];
    end else begin
      if (accept) begin
        tail   <= ptr_add(tail, n_wr);
        drop_q <= '0;
      end
      if (pop) begin
        head <= ptr_add(head, n_pop);
        pc_q <= pc_q + (is32 ? 32'd4 : 32'd2);
      end
      occ <= OCC_W'(int'(occ) + n_wr - n_pop);
    end
  end
endmodule
